// File: rtl/pico_mips_mc_if.sv
// pico_mips_mc_if -- bus bundle between the pico_mips_mc core and its surroundings.
//   imem_addr / imem_data : asynchronous instruction fetch (address = PC)
//   in_valid / sw / in_ack: input handshake, in_ack pulses when sw is consumed
//   LED / led_valid       : display register and its one-cycle update strobe
//   busy / halted         : core status (MUL in progress, HALT state)
//   flags                 : architectural condition flags {Z, C, S}
interface pico_mips_mc_if #(
    parameter int N  = 8,
    parameter int P  = 6,
    parameter int RA = 3
);
    localparam int I = 4 + 2*RA + N;

    logic [P-1:0] imem_addr;
    logic [I-1:0] imem_data;
    logic         in_valid;
    logic [N-1:0] sw;
    logic         in_ack;
    logic [N-1:0] LED;
    logic         led_valid;
    logic         busy;
    logic         halted;
    logic [2:0]   flags;

    modport master (
        output imem_addr, in_ack, LED, led_valid, busy, halted, flags,
        input  imem_data, in_valid, sw
    );

    modport slave (
        input  imem_addr, in_ack, LED, led_valid, busy, halted, flags,
        output imem_data, in_valid, sw
    );
endinterface

// File: rtl/pico_mips_mc.sv
// pico_mips_mc -- small multi-cycle accumulator-style processor.
//   clk   : sole clock, all state changes on the rising edge
//   reset : synchronous, active low; returns the core to RUN at PC 0
//   bus   : pico_mips_mc_if master port (fetch, input handshake, LED, status)
// Instruction word: {opcode[3:0], rd[RA-1:0], rs[RA-1:0], imm[N-1:0]}.
// MUL/MULI run for N cycles in the MUL state on operands captured at decode.
module pico_mips_mc #(
    parameter int N  = 8,
    parameter int P  = 6,
    parameter int RA = 3
) (
    input  logic           clk,
    input  logic           reset,
    pico_mips_mc_if.master bus
);
    localparam int I  = 4 + 2*RA + N;
    localparam int NR = 2**RA;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] MAX_VAL = {1'b0, {(N-1){1'b1}}};

    typedef enum logic [1:0] {RUN, MUL, WAIT_IN, HALT} state_t;
    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_MULI,
        OP_IN, OP_OUT, OP_BEQ, OP_BNE, OP_JMP, OP_HALT
    } opcode_t;

    state_t         state, state_nx;
    logic [P-1:0]   pc, pc_nx, pc_inc;
    logic [N-1:0]   regs [NR];
    logic           fz, fc, fs;
    logic [N-1:0]   led_q;
    logic           led_valid_q;
    logic [CW-1:0]  mul_cnt;
    logic [N-1:0]   mul_a, mul_b;
    logic [RA-1:0]  mul_rd;

    logic [3:0]     opc;
    logic [RA-1:0]  rd_a, rs_a;
    logic [N-1:0]   imm, rd_val, rs_val;

    logic signed [2*N-1:0] ext_a, ext_b, prod;
    logic [N-1:0]   mul_res;

    logic           we, flag_we, z_nx, c_nx, s_nx, led_ld, mul_ld, in_ack_c, arith;
    logic [RA-1:0]  wa;
    logic [N-1:0]   wd;
    logic [N:0]     sum;

    assign opc    = bus.imem_data[I-1 -: 4];
    assign rd_a   = bus.imem_data[I-5 -: RA];
    assign rs_a   = bus.imem_data[I-5-RA -: RA];
    assign imm    = bus.imem_data[N-1:0];
    assign rd_val = regs[rd_a];
    assign rs_val = regs[rs_a];
    assign pc_inc = pc + P'(1);

    // Q1.(N-1) product: bits [2N-2:N-1] of the full signed product; only
    // (-1)x(-1) overflows that range and is clamped to the largest positive.
    assign ext_a   = {{N{mul_a[N-1]}}, mul_a};
    assign ext_b   = {{N{mul_b[N-1]}}, mul_b};
    assign prod    = ext_a * ext_b;
    assign mul_res = (mul_a == MIN_VAL && mul_b == MIN_VAL) ? MAX_VAL : N'(prod >>> (N-1));

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        we       = 1'b0;
        wa       = rd_a;
        wd       = rd_val;
        flag_we  = 1'b0;
        z_nx     = fz;
        c_nx     = fc;
        s_nx     = fs;
        led_ld   = 1'b0;
        mul_ld   = 1'b0;
        in_ack_c = 1'b0;
        arith    = 1'b0;
        sum      = '0;
        unique case (state)
            RUN: begin
                pc_nx = pc_inc;
                case (opc)
                    OP_ADD:  begin sum = {1'b0, rd_val} + {1'b0, rs_val}; arith = 1'b1; end
                    OP_ADDI: begin sum = {1'b0, rd_val} + {1'b0, imm};    arith = 1'b1; end
                    // Bit N of the N+1-bit difference is the borrow.
                    OP_SUB:  begin sum = {1'b0, rd_val} - {1'b0, rs_val}; arith = 1'b1; end
                    OP_SUBI: begin sum = {1'b0, rd_val} - {1'b0, imm};    arith = 1'b1; end
                    OP_MUL, OP_MULI: begin
                        mul_ld   = 1'b1;
                        pc_nx    = pc;
                        state_nx = MUL;
                    end
                    OP_IN: begin
                        if (bus.in_valid) begin
                            we       = 1'b1;
                            wd       = bus.sw;
                            in_ack_c = 1'b1;
                        end else begin
                            pc_nx    = pc;
                            state_nx = WAIT_IN;
                        end
                    end
                    OP_OUT:  led_ld = 1'b1;
                    OP_BEQ:  if (fz)  pc_nx = imm[P-1:0];
                    OP_BNE:  if (!fz) pc_nx = imm[P-1:0];
                    OP_JMP:  pc_nx = imm[P-1:0];
                    OP_HALT: begin
                        pc_nx    = pc;
                        state_nx = HALT;
                    end
                    default: ;
                endcase
                if (arith) begin
                    we      = 1'b1;
                    wd      = sum[N-1:0];
                    flag_we = 1'b1;
                    z_nx    = (sum[N-1:0] == '0);
                    c_nx    = sum[N];
                    s_nx    = sum[N-1];
                end
            end
            MUL: begin
                if (mul_cnt == CW'(N-1)) begin
                    we       = 1'b1;
                    wa       = mul_rd;
                    wd       = mul_res;
                    flag_we  = 1'b1;
                    z_nx     = (mul_res == '0);
                    c_nx     = 1'b0;
                    s_nx     = mul_res[N-1];
                    pc_nx    = pc_inc;
                    state_nx = RUN;
                end
            end
            WAIT_IN: begin
                if (bus.in_valid) begin
                    we       = 1'b1;
                    wd       = bus.sw;
                    in_ack_c = 1'b1;
                    pc_nx    = pc_inc;
                    state_nx = RUN;
                end
            end
            HALT: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            pc          <= '0;
            regs        <= '{default: '0};
            fz          <= 1'b0;
            fc          <= 1'b0;
            fs          <= 1'b0;
            led_q       <= '0;
            led_valid_q <= 1'b0;
            mul_cnt     <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_rd      <= '0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            if (we) regs[wa] <= wd;
            if (flag_we) begin
                fz <= z_nx;
                fc <= c_nx;
                fs <= s_nx;
            end
            if (led_ld) led_q <= rd_val;
            led_valid_q <= led_ld;
            mul_cnt     <= (state == MUL) ? mul_cnt + CW'(1) : '0;
            if (mul_ld) begin
                mul_a  <= rd_val;
                mul_b  <= (opc == OP_MULI) ? imm : rs_val;
                mul_rd <= rd_a;
            end
        end
    end

    assign bus.imem_addr = pc;
    assign bus.LED       = led_q;
    assign bus.led_valid = led_valid_q;
    assign bus.busy      = (state == MUL);
    assign bus.halted    = (state == HALT);
    // in_ack is combinational so it lands in the consuming cycle; masked in reset.
    assign bus.in_ack    = in_ack_c & reset;
    assign bus.flags     = {fz, fc, fs};
endmodule

// File: tb/tb_pico_mips_mc.sv
module tb_pico_mips_mc;
    localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, ADDI = 4'd2, SUB = 4'd3, SUBI = 4'd4,
                           MULR = 4'd5, MULI = 4'd6, IN = 4'd7, OUT = 4'd8, BEQ = 4'd9,
                           BNE = 4'd10, JMP = 4'd11, HLT = 4'd12;

    logic clk;
    logic reset;
    logic [17:0] imem [64];
    logic [7:0]  exp_q [$];
    int n_chk  = 0;
    int n_pass = 0;

    pico_mips_mc_if #(.N(8), .P(6), .RA(3)) bus ();

    pico_mips_mc #(.N(8), .P(6), .RA(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_data = imem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_imem();
        for (int i = 0; i < 64; i++) imem[i] = '0;
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic wait_halt(input string name, input int max_cycles);
        int n;
        n = 0;
        while (bus.halted !== 1'b1 && n < max_cycles) begin
            step();
            n++;
        end
        chk(name, bus.halted, 1);
    endtask

    // Scoreboard monitor: every led_valid pulse consumes one expected LED value.
    always @(negedge clk) begin
        if (bus.led_valid === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL led_unexpected: got LED 0x%0h expected no update", bus.LED);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.LED === e) n_pass++;
                else $display("FAIL led_value: got 0x%0h expected 0x%0h", bus.LED, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] pc_seq [10];
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.sw       = '0;

        // Add with carry, OUT strobe, HALT freeze
        clr_imem();
        imem[0] = enc(ADDI, 1, 0, 8'h05);
        imem[1] = enc(ADDI, 1, 0, 8'hFD);
        imem[2] = enc(OUT,  1, 0, 8'h00);
        imem[3] = enc(HLT,  0, 0, 8'h00);
        exp_q.push_back(8'h02);
        reset = 1'b0;
        step();
        step();
        chk("rst_pc", bus.imem_addr, 0);
        chk("rst_led", bus.LED, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_led_valid", bus.led_valid, 0);
        chk("rst_in_ack", bus.in_ack, 0);
        chk("rst_flags", bus.flags, 0);
        reset = 1'b1;
        step();
        step();
        chk("add_pc", bus.imem_addr, 2);
        chk("add_flags_c", bus.flags, 3'b010);
        chk("out_led_valid_low", bus.led_valid, 0);
        step();
        chk("out_led_valid_pulse", bus.led_valid, 1);
        step();
        chk("out_led_valid_end", bus.led_valid, 0);
        chk("halt_enter", bus.halted, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_pc", bus.imem_addr, 3);
            chk("halt_state", bus.halted, 1);
        end

        // MUL timing: 0x40 * 0x40 = 0x20
        clr_imem();
        imem[0] = enc(ADDI, 1, 0, 8'h40);
        imem[1] = enc(ADDI, 2, 0, 8'h40);
        imem[2] = enc(MULR, 1, 2, 8'h00);
        imem[3] = enc(OUT,  1, 0, 8'h00);
        imem[4] = enc(HLT,  0, 0, 8'h00);
        exp_q.push_back(8'h20);
        do_reset();
        step();
        step();
        chk("mul_decode_busy", bus.busy, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("mul_busy", bus.busy, 1);
            chk("mul_pc_hold", bus.imem_addr, 2);
        end
        step();
        chk("mul_done_busy", bus.busy, 0);
        chk("mul_done_pc", bus.imem_addr, 3);
        wait_halt("mul_halt", 20);

        // IN with wait states, then immediate IN
        clr_imem();
        imem[0] = enc(IN,  3, 0, 8'h00);
        imem[1] = enc(OUT, 3, 0, 8'h00);
        imem[2] = enc(IN,  4, 0, 8'h00);
        imem[3] = enc(OUT, 4, 0, 8'h00);
        imem[4] = enc(HLT, 0, 0, 8'h00);
        exp_q.push_back(8'h7A);
        exp_q.push_back(8'h11);
        bus.sw = 8'h7A;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("in_wait_pc", bus.imem_addr, 0);
            chk("in_wait_ack", bus.in_ack, 0);
            step();
        end
        bus.in_valid = 1'b1;
        #1;
        chk("in_ack_pulse", bus.in_ack, 1);
        chk("in_ack_pc", bus.imem_addr, 0);
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("in_done_pc", bus.imem_addr, 1);
        chk("in_ack_single", bus.in_ack, 0);
        step();
        bus.sw       = 8'h11;
        bus.in_valid = 1'b1;
        #1;
        chk("in_fast_ack", bus.in_ack, 1);
        step();
        bus.in_valid = 1'b0;
        chk("in_fast_pc", bus.imem_addr, 3);
        wait_halt("in_halt", 20);

        // Branches and PC wrap
        clr_imem();
        imem[0]     = enc(ADDI, 1, 0, 8'h01);
        imem[1]     = enc(SUBI, 1, 0, 8'h01);
        imem[2]     = enc(BEQ,  0, 0, 8'h10);
        imem[6'h10] = enc(ADDI, 1, 0, 8'h02);
        imem[6'h11] = enc(SUBI, 1, 0, 8'h01);
        imem[6'h12] = enc(BEQ,  0, 0, 8'h20);
        imem[6'h13] = enc(BNE,  0, 0, 8'h20);
        imem[6'h20] = enc(JMP,  0, 0, 8'h3F);
        imem[6'h3F] = enc(NOP,  0, 0, 8'h00);
        pc_seq = '{6'h00, 6'h01, 6'h02, 6'h10, 6'h11, 6'h12, 6'h13, 6'h20, 6'h3F, 6'h00};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("branch_pc_%0d", i), bus.imem_addr, pc_seq[i]);
            step();
        end

        // Saturating MUL/MULI, ADD with rd==rs, SUB, fractional MULI, BEQ
        clr_imem();
        imem[0]     = enc(ADDI, 1, 0, 8'h80);
        imem[1]     = enc(ADDI, 2, 0, 8'h80);
        imem[2]     = enc(MULR, 1, 2, 8'h00);
        imem[3]     = enc(OUT,  1, 0, 8'h00);
        imem[4]     = enc(ADDI, 3, 0, 8'h80);
        imem[5]     = enc(MULI, 3, 0, 8'h80);
        imem[6]     = enc(OUT,  3, 0, 8'h00);
        imem[7]     = enc(ADD,  3, 3, 8'h00);
        imem[8]     = enc(OUT,  3, 0, 8'h00);
        imem[9]     = enc(SUB,  3, 1, 8'h00);
        imem[10]    = enc(OUT,  3, 0, 8'h00);
        imem[11]    = enc(MULI, 3, 0, 8'hC0);
        imem[12]    = enc(OUT,  3, 0, 8'h00);
        imem[13]    = enc(SUBI, 1, 0, 8'h7F);
        imem[14]    = enc(BEQ,  0, 0, 8'h18);
        imem[6'h18] = enc(OUT,  1, 0, 8'h00);
        imem[6'h19] = enc(HLT,  0, 0, 8'h00);
        exp_q.push_back(8'h7F);
        exp_q.push_back(8'h7F);
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'h7F);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'h00);
        do_reset();
        step();
        step();
        chk("sat_pre_flags_s", bus.flags, 3'b001);
        for (int i = 0; i < 9; i++) step();
        chk("sat_pc", bus.imem_addr, 3);
        chk("sat_flags", bus.flags, 3'b000);
        wait_halt("sat_halt", 200);
        chk("final_flags_z", bus.flags, 3'b100);
        chk("final_pc", bus.imem_addr, 6'h19);

        // Reset in the middle of a MUL
        clr_imem();
        imem[0] = enc(ADDI, 1, 0, 8'h40);
        imem[1] = enc(OUT,  1, 0, 8'h00);
        imem[2] = enc(MULR, 1, 1, 8'h00);
        imem[3] = enc(HLT,  0, 0, 8'h00);
        exp_q.push_back(8'h40);
        do_reset();
        step();
        step();
        step();
        step();
        step();
        chk("mid_mul_busy", bus.busy, 1);
        chk("mid_mul_led", bus.LED, 8'h40);
        reset = 1'b0;
        step();
        chk("mid_rst_pc", bus.imem_addr, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_led", bus.LED, 0);
        chk("mid_rst_halted", bus.halted, 0);
        step();

        chk("led_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pico_mips_mc.md
PICO_MIPS_MC -- requirements
Module: pico_mips_mc

Interface
REQ-001 SHALL have parameter N, default 8, meaning data/register width in bits.
REQ-002 SHALL have parameter P, default 6, meaning program-counter and instruction-address width.
REQ-003 SHALL have parameter RA, default 3, meaning register-address width, giving 2**RA general registers.
REQ-004 SHALL define instruction width I = 4 + 2*RA + N, with fields opcode [I-1:I-4], rd [I-5:I-4-RA], rs [I-5-RA:N] and imm [N-1:0].
REQ-005 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-007 SHALL have port imem_addr, output, P, instruction address, equal to the PC.
REQ-008 SHALL have port imem_data, input, I, instruction read combinationally from imem_addr in the same cycle.
REQ-009 SHALL have port in_valid, input, 1, meaning sw holds valid input data.
REQ-010 SHALL have port sw, input, N, input data.
REQ-011 SHALL have port in_ack, output, 1, one-cycle pulse when sw is consumed.
REQ-012 SHALL have port LED, output, N, display register.
REQ-013 SHALL have port led_valid, output, 1, one-cycle pulse in the cycle after LED is updated.
REQ-014 SHALL have port busy, output, 1, high while a MUL is in progress.
REQ-015 SHALL have port halted, output, 1, high in HALT state.

Function
REQ-016 SHALL implement states RUN, MUL, WAIT_IN and HALT; each RUN instruction completes in one cycle unless stated otherwise.
REQ-017 SHALL decode opcodes 0 NOP, 1 ADD rd=rd+rs, 2 ADDI rd=rd+imm, 3 SUB rd=rd-rs, 4 SUBI rd=rd-imm, 5 MUL rd=rd*rs, 6 MULI rd=rd*imm, 7 IN rd=sw, 8 OUT LED=rd, 9 BEQ, 10 BNE, 11 JMP, 12 HALT; opcodes 13-15 SHALL behave as NOP.
REQ-018 SHALL perform add/sub modulo 2**N and update flags Z (result==0), C (carry out, or borrow for SUB) and S (result MSB); only ADD/ADDI/SUB/SUBI/MUL/MULI SHALL update flags.
REQ-019 SHALL compute MUL/MULI as the signed 2N-bit product of the operands, writing product bits [2N-2:N-1] (Q1.(N-1) fractional, saturated to 2**(N-1)-1 for (-1)x(-1)), with Z and S from the written result and C cleared.
REQ-020 SHALL enter MUL for exactly N cycles, with busy high, PC held and no register write until the last MUL cycle, then write rd and return to RUN with PC+1.
REQ-021 SHALL take branch target imm[P-1:0]: BEQ when Z=1, BNE when Z=0, JMP always; otherwise PC+1.
REQ-022 SHALL wrap the PC from 2**P-1 to 0 on increment.
REQ-023 SHALL complete IN in the same cycle when in_valid=1 (write rd, pulse in_ack, PC+1); otherwise it SHALL enter WAIT_IN, hold the PC, and complete in the first cycle with in_valid=1.
REQ-024 SHALL load LED with rd on OUT and pulse led_valid the following cycle; LED SHALL hold its value otherwise.
REQ-025 SHALL in HALT hold the PC and all state; only reset leaves HALT.
REQ-026 SHALL read registers with rd==rs using the pre-write values.

Reset
REQ-027 SHALL apply reset (reset=0 at a rising clk edge) with priority over all activity, including mid-MUL and WAIT_IN: PC=0, all registers=0, flags=0, LED=0, in_ack=0, led_valid=0, busy=0, halted=0, state=RUN.
REQ-028 SHALL fetch instruction 0 in the first cycle after reset is released.

Verification
REQ-029 SHALL cover: ADDI r1,5; ADDI r1,0xFD; OUT r1 -> LED=0x02, C=1, led_valid pulses one cycle after the OUT cycle.
REQ-030 SHALL cover: r1=0x40, r2=0x40, MUL r1,r2 -> busy high for 8 cycles, r1=0x20, PC advances only after the 8th cycle.
REQ-031 SHALL cover: IN r3 with in_valid low for 3 cycles and sw=0x7A -> PC held 3 cycles, r3=0x7A, in_ack single pulse in the 4th cycle.
REQ-032 SHALL cover: SUBI r1,r1 value 1 from 1, then BEQ 0x10 -> PC=0x10; a repeat with nonzero result -> PC+1; JMP 0x3F then NOP -> PC wraps to 0.
REQ-033 SHALL cover: HALT -> halted=1 and PC frozen for 10 cycles; reset asserted during MUL -> next cycle PC=0, busy=0, LED=0.
REQ-034 SHALL cover: r1=0x80, r2=0x80, MULI/MUL (-1)x(-1) -> r1=0x7F, S=0.
